// File: rtl/hfu_pkg.sv
// rtl/hfu_pkg.sv - shared types, defaults and helpers for the hazard/forward unit
package hfu_pkg;

    localparam int HFU_REG_AW     = 3;
    localparam int HFU_NSRC       = 2;
    localparam int HFU_DEPTH      = 2;
    localparam int HFU_LOAD_STAGE = 2;
    localparam int HFU_ZERO_REG   = 1;

    // Widest register address an entry can hold; narrower addresses are zero-extended.
    localparam int HFU_MAX_AW = 8;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic [HFU_MAX_AW-1:0] rd;
    } hfu_entry_t;

    function automatic int hfu_selw(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic hfu_is_producer(input hfu_entry_t e, input bit zero_reg);
        return e.valid && e.regwrite && !(zero_reg && (e.rd == '0));
    endfunction

endpackage

// File: rtl/hfu_prio_match.sv
// rtl/hfu_prio_match.sv - nearest-producer select for one source operand
module hfu_prio_match
    import hfu_pkg::*;
#(
    parameter int REG_AW   = HFU_REG_AW,
    parameter int DEPTH    = HFU_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    parameter int SELW     = hfu_selw(HFU_DEPTH)
) (
    input  logic                   en,
    input  logic [REG_AW-1:0]      addr,
    input  hfu_entry_t [DEPTH-1:0] entries,
    output logic [SELW-1:0]        sel
);

    // Scan oldest to youngest so the nearest matching stage is the last one written.
    always_comb begin
        sel = '0;
        if (en) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (hfu_is_producer(entries[k-1], ZERO_REG) &&
                    (entries[k-1].rd == HFU_MAX_AW'(addr))) begin
                    sel = SELW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - destination tag pipeline, bypass selects and load-use stall
module hazard_forward_unit
    import hfu_pkg::*;
#(
    parameter int REG_AW     = HFU_REG_AW,
    parameter int NSRC       = HFU_NSRC,
    parameter int DEPTH      = HFU_DEPTH,
    parameter int LOAD_STAGE = HFU_LOAD_STAGE,
    parameter int ZERO_REG   = HFU_ZERO_REG
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [NSRC*REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]                 id_rd,
    input  logic                              id_regwrite,
    input  logic                              id_is_load,
    input  logic                              flush,
    output logic                              stall,
    output logic [NSRC*hfu_selw(DEPTH)-1:0]   fwd_sel,
    output logic [15:0]                       stall_count
);

    localparam int SELW = hfu_selw(DEPTH);
    localparam int LD_N = (LOAD_STAGE > 1) ? LOAD_STAGE - 1 : 1;
    localparam bit ZR   = (ZERO_REG != 0);

    // ent_q[0] is EX, ent_q[k] is post-EX stage k.
    hfu_entry_t [DEPTH:0]      ent_q;
    // Load flags are only kept for the stages that can still cause a stall.
    logic [LD_N-1:0]           load_q;
    logic [NSRC*REG_AW-1:0]    ex_rs_q;
    logic [15:0]               stall_count_q;
    hfu_entry_t                id_entry;
    logic                      load_hit;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.regwrite = id_regwrite;
        id_entry.rd       = HFU_MAX_AW'(id_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q   <= '0;
            load_q  <= '0;
            ex_rs_q <= '0;
        end else begin
            for (int k = DEPTH; k >= 1; k--) begin
                ent_q[k] <= ent_q[k-1];
            end
            ent_q[0]  <= (flush || stall) ? '0 : id_entry;
            load_q[0] <= id_is_load;
            for (int s = LD_N - 1; s >= 1; s--) begin
                load_q[s] <= load_q[s-1];
            end
            ex_rs_q <= id_rs;
        end
    end

    // A load still short of the stage that carries its data blocks any ID reader.
    always_comb begin
        load_hit = 1'b0;
        for (int s = 0; s <= LOAD_STAGE - 2; s++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (load_q[s] && hfu_is_producer(ent_q[s], ZR) &&
                    (ent_q[s].rd == HFU_MAX_AW'(id_rs[i*REG_AW +: REG_AW]))) begin
                    load_hit = 1'b1;
                end
            end
        end
    end

    assign stall = id_valid && !flush && load_hit;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hfu_prio_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZR),
            .SELW     (SELW)
        ) u_match (
            .en      (ent_q[0].valid),
            .addr    (ex_rs_q[i*REG_AW +: REG_AW]),
            .entries (ent_q[DEPTH:1]),
            .sel     (fwd_sel[i*SELW +: SELW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

    localparam int DEPTH      = 2;
    localparam int LOAD_STAGE = 2;
    localparam int SELW       = 2;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_regwrite, id_is_load, flush;
    logic [5:0]  id_rs;
    logic [2:0]  id_rd;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_count;

    logic        s_rst, s_id_valid, s_id_regwrite, s_id_is_load, s_flush;
    logic [5:0]  s_id_rs;
    logic [2:0]  s_id_rd;
    logic        s_stall;
    logic [11:0] s_fwd_sel;
    logic [15:0] s_stall_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .fwd_sel(fwd_sel), .stall_count(stall_count)
    );

    hazard_forward_unit #(.DEPTH(32), .LOAD_STAGE(32)) dut_sat (
        .clk(clk), .rst(s_rst), .id_valid(s_id_valid), .id_rs(s_id_rs), .id_rd(s_id_rd),
        .id_regwrite(s_id_regwrite), .id_is_load(s_id_is_load), .flush(s_flush),
        .stall(s_stall), .fwd_sel(s_fwd_sel), .stall_count(s_stall_count)
    );

    // Reference model: history of what entered EX, newest at the front.
    typedef struct {
        bit valid;
        bit rw;
        bit ld;
        int rd;
        int rs0;
        int rs1;
    } mrec_t;

    mrec_t       mq[$];
    int unsigned m_count;

    function automatic bit m_prod(input mrec_t e);
        return e.valid && e.rw && (e.rd != 0);
    endfunction

    function automatic int m_fwd(input int i);
        int a;
        if (!mq[0].valid) return 0;
        a = (i == 0) ? mq[0].rs0 : mq[0].rs1;
        for (int k = 1; k <= DEPTH; k++)
            if (m_prod(mq[k]) && mq[k].rd == a) return k;
        return 0;
    endfunction

    function automatic bit m_stall();
        if (!id_valid || flush) return 1'b0;
        for (int s = 0; s <= LOAD_STAGE - 2; s++)
            if (m_prod(mq[s]) && mq[s].ld &&
                (mq[s].rd == int'(id_rs[2:0]) || mq[s].rd == int'(id_rs[5:3])))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear();
        mrec_t z;
        z = '{valid: 1'b0, rw: 1'b0, ld: 1'b0, rd: 0, rs0: 0, rs1: 0};
        mq.delete();
        for (int k = 0; k <= DEPTH; k++) mq.push_back(z);
        m_count = 0;
    endfunction

    always @(posedge clk) begin : model_update
        mrec_t n;
        bit    st;
        st = m_stall();
        if (rst) begin
            m_clear();
        end else begin
            n.valid = id_valid && !flush && !st;
            n.rw    = id_regwrite;
            n.ld    = id_is_load;
            n.rd    = int'(id_rd);
            n.rs0   = int'(id_rs[2:0]);
            n.rs1   = int'(id_rs[5:3]);
            mq.push_front(n);
            void'(mq.pop_back());
            if (st && m_count < 65535) m_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs0, input int rs1, input int rd,
                          input bit rw, input bit ld);
        id_valid    = v;
        id_rs       = {3'(rs1), 3'(rs0)};
        id_rd       = 3'(rd);
        id_regwrite = rw;
        id_is_load  = ld;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        set_id(1, 1, 1, 1, 1, 1);
        tick();
        tick();
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        n_vec++;
        if (fwd_sel !== 4'h0) begin n_err++; $display("FAIL reset_fwd: got %0h expected 0", fwd_sel); end
        n_vec++;
        if (stall_count !== 16'h0) begin n_err++; $display("FAIL reset_count: got %0h expected 0", stall_count); end
        set_id(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_chain();
        idle(3);
        set_id(1, 1, 2, 3, 1, 0);
        tick();
        set_id(1, 3, 3, 4, 1, 0);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL alu_no_stall: got %0b expected 0", stall); end
        tick();
        set_id(1, 3, 4, 5, 1, 0);
        #1;
        n_vec++;
        if (fwd_sel !== {2'd1, 2'd1}) begin n_err++; $display("FAIL alu_fwd_mem: got %0h expected 5", fwd_sel); end
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (fwd_sel !== {2'd1, 2'd2}) begin n_err++; $display("FAIL alu_fwd_wb: got %0h expected 6", fwd_sel); end
        tick();
    endtask

    task automatic test_priority();
        idle(3);
        set_id(1, 0, 0, 5, 1, 0); tick();
        set_id(1, 0, 0, 5, 1, 0); tick();
        set_id(1, 5, 7, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (fwd_sel !== {2'd0, 2'd1}) begin n_err++; $display("FAIL prio_same_rd: got %0h expected 1", fwd_sel); end
        idle(3);
        set_id(1, 0, 0, 6, 1, 0); tick();
        set_id(1, 0, 0, 5, 1, 0); tick();
        set_id(1, 5, 6, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (fwd_sel !== {2'd2, 2'd1}) begin n_err++; $display("FAIL prio_split: got %0h expected 9", fwd_sel); end
        tick();
    endtask

    task automatic test_load_use();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        set_id(1, 0, 0, 2, 1, 1);
        tick();
        set_id(1, 2, 1, 7, 1, 0);
        #1;
        n_vec++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b expected 1", stall); end
        tick();
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_end: got %0b expected 0", stall); end
        n_vec++;
        if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count: got %0h expected 1", stall_count); end
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (fwd_sel !== {2'd0, 2'd2}) begin n_err++; $display("FAIL lu_fwd: got %0h expected 2", fwd_sel); end
        tick();
    endtask

    task automatic test_zero_flush();
        idle(3);
        set_id(1, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 1, 1, 0);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %0b expected 0", stall); end
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (fwd_sel !== 4'h0) begin n_err++; $display("FAIL zero_fwd: got %0h expected 0", fwd_sel); end
        idle(3);
        set_id(1, 0, 0, 2, 1, 1);
        tick();
        set_id(1, 2, 1, 7, 1, 0);
        flush = 1'b1;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL flush_over_stall: got %0b expected 0", stall); end
        tick();
        flush = 1'b0;
        idle(3);
        set_id(1, 0, 0, 2, 1, 0);
        tick();
        set_id(1, 2, 1, 7, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (fwd_sel !== 4'h0) begin n_err++; $display("FAIL flush_kill_ex: got %0h expected 0", fwd_sel); end
        n_vec++;
        if (stall_count !== 16'd1) begin n_err++; $display("FAIL flush_count: got %0h expected 1", stall_count); end
        tick();
    endtask

    task automatic test_random();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom % 400) == 0;
            flush = ($urandom % 12) == 0;
            set_id(($urandom % 6) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom % 4) != 0, ($urandom % 3) == 0);
            #1;
            n_vec++;
            if (stall !== m_stall()) begin
                n_err++; $display("FAIL rnd_stall c=%0d: got %0b expected %0b", c, stall, m_stall());
            end
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (fwd_sel[i*SELW +: SELW] !== SELW'(m_fwd(i))) begin
                    n_err++;
                    $display("FAIL rnd_fwd%0d c=%0d: got %0d expected %0d", i, c, fwd_sel[i*SELW +: SELW], m_fwd(i));
                end
            end
            n_vec++;
            if (stall_count !== 16'(m_count)) begin
                n_err++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, stall_count, m_count);
            end
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        idle(1);
    endtask

    task automatic test_saturation();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        s_id_valid = 1'b1;
        s_id_rs = {3'd1, 3'd1};
        s_id_rd = 3'd1;
        s_id_regwrite = 1'b1;
        s_id_is_load = 1'b1;
        #1;
        n_vec++;
        if (s_stall !== 1'b0) begin n_err++; $display("FAIL sat_first: got %0b expected 0", s_stall); end
        repeat (32) tick();
        n_vec++;
        if (s_stall_count !== 16'd31) begin n_err++; $display("FAIL sat_period_count: got %0d expected 31", s_stall_count); end
        n_vec++;
        if (s_stall !== 1'b0) begin n_err++; $display("FAIL sat_gap: got %0b expected 0", s_stall); end
        tick();
        n_vec++;
        if (s_stall !== 1'b1) begin n_err++; $display("FAIL sat_restall: got %0b expected 1", s_stall); end
        repeat (2116 * 32 - 33) tick();
        n_vec++;
        if (s_stall_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_count: got %0h expected ffff", s_stall_count); end
    endtask

    initial begin
        m_clear();
        rst = 1'b1;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        s_rst = 1'b1;
        s_flush = 1'b0;
        s_id_valid = 1'b0;
        s_id_rs = '0;
        s_id_rd = '0;
        s_id_regwrite = 1'b0;
        s_id_is_load = 1'b0;
        test_reset();
        test_alu_chain();
        test_priority();
        test_load_use();
        test_zero_flush();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
